// File: rtl/data_mem_pkg.sv
// Shared encodings for the parametrised data memory: access sizes and FSM states.
package data_mem_pkg;

    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b011;
    localparam logic [2:0] SZ_WORD = 3'b111;

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] READ_WAIT = 1'b1;

endpackage

// File: rtl/data_mem_lane.sv
// Store lane steering / byte enables and load lane extraction with sign/zero extension.
module data_mem_lane
    import data_mem_pkg::*;
(
    input  logic [1:0]  i_st_off,
    input  logic [2:0]  i_st_size,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_data,
    output logic        o_misaligned,
    input  logic [31:0] i_ld_word,
    input  logic [1:0]  i_ld_off,
    input  logic [3:0]  i_ld_sm,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Unknown size encodings fall through to the word case.
    always_comb begin
        o_st_be      = 4'b1111;
        o_st_data    = i_st_data;
        o_misaligned = |i_st_off;
        unique case (i_st_size)
            SZ_BYTE: begin
                o_st_be      = 4'b0001 << i_st_off;
                o_st_data    = {4{i_st_data[7:0]}};
                o_misaligned = 1'b0;
            end
            SZ_HALF: begin
                o_st_be      = i_st_off[1] ? 4'b1100 : 4'b0011;
                o_st_data    = {2{i_st_data[15:0]}};
                o_misaligned = i_st_off[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte    = i_ld_word[{i_ld_off, 3'b000} +: 8];
        w_half    = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        o_ld_data = i_ld_word;
        unique case (i_ld_sm[2:0])
            SZ_BYTE: o_ld_data = {{24{i_ld_sm[3] & w_byte[7]}}, w_byte};
            SZ_HALF: o_ld_data = {{16{i_ld_sm[3] & w_half[15]}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_param.sv
// Parametrised RV32I data memory: byte-masked word array, LED register, optional
// two-cycle read with pipeline stall, and registered fault pulse.
module data_mem_param
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter logic [31:0] LED_ADDR     = 32'h0000_2000,
    parameter int unsigned LED_WIDTH    = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       INIT_FILE    = "verilog/data.hex"
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          addr,
    input  logic [31:0]          write_data,
    input  logic                 memwrite,
    input  logic                 memread,
    input  logic [3:0]           sign_mask,
    output logic [31:0]          read_data,
    output logic [LED_WIDTH-1:0] led,
    output logic                 clk_stall,
    output logic                 fault
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [0:0]  r_state;
    logic [31:0] r_led;
    logic [31:0] r_word;
    logic [1:0]  r_off;
    logic [3:0]  r_sm;
    logic        r_ld_fault;
    logic        r_fault;
    logic [31:0] r_out;

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_is_led;
    logic          w_misal;
    logic          w_bad;
    logic          w_ld;
    logic          w_st;
    logic [3:0]    w_be;
    logic [31:0]   w_st_data;
    logic [31:0]   w_ext;

    // Unsigned subtraction makes addresses below the base wrap and fail the range test.
    assign w_off      = addr - BASE_ADDR;
    assign w_idx      = w_off[AW+1:2];
    assign w_in_range = w_off < SPAN;
    assign w_is_led   = addr == LED_ADDR;
    assign w_bad      = !w_is_led && (w_misal || !w_in_range);
    assign w_ld       = (r_state == IDLE) && memread;
    assign w_st       = (r_state == IDLE) && memwrite && !memread;

    data_mem_lane u_lane (
        .i_st_off     (addr[1:0]),
        .i_st_size    (sign_mask[2:0]),
        .i_st_data    (write_data),
        .o_st_be      (w_be),
        .o_st_data    (w_st_data),
        .o_misaligned (w_misal),
        .i_ld_word    (r_word),
        .i_ld_off     (r_off),
        .i_ld_sm      (r_sm),
        .o_ld_data    (w_ext)
    );

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_st && !w_bad && !w_is_led) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_st_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_led      <= 32'h0;
            r_word     <= 32'h0;
            r_off      <= 2'b00;
            r_sm       <= 4'h0;
            r_ld_fault <= 1'b0;
            r_fault    <= 1'b0;
            r_out      <= 32'h0;
        end else begin
            r_fault <= 1'b0;
            if (w_st) begin
                if (w_is_led) r_led <= write_data;
                else if (w_bad) r_fault <= 1'b1;
            end
            if (w_ld) begin
                r_off  <= addr[1:0];
                r_sm   <= sign_mask;
                r_word <= w_bad ? 32'h0 : (w_is_led ? r_led : r_mem[w_idx]);
                if (READ_LATENCY == 2) begin
                    r_state    <= READ_WAIT;
                    r_ld_fault <= w_bad;
                end else begin
                    r_fault <= w_bad;
                end
            end
            if (r_state == READ_WAIT) begin
                r_state <= IDLE;
                r_out   <= w_ext;
                r_fault <= r_ld_fault;
            end
        end
    end

    assign read_data = (READ_LATENCY == 2) ? r_out : w_ext;
    assign led       = r_led[LED_WIDTH-1:0];
    assign clk_stall = (r_state == READ_WAIT);
    assign fault     = r_fault;

endmodule

// File: tb/tb_data_mem_param.sv
// Scoreboard bench for data_mem_param: one instance per read latency, directed vectors.
module tb_data_mem_param;

    typedef struct packed {
        logic        is_load;
        logic [31:0] data;
        logic        fault;
        int          due;
        int          tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   tag_n = 0;

    exp_t q1[$];
    exp_t q2[$];

    logic [31:0] addr1 = '0, wd1 = '0, rd1;
    logic        we1 = 1'b0, re1 = 1'b0, stall1, fault1;
    logic [3:0]  sm1 = '0;
    logic [7:0]  led1;

    logic [31:0] addr2 = '0, wd2 = '0, rd2;
    logic        we2 = 1'b0, re2 = 1'b0, stall2, fault2;
    logic [3:0]  sm2 = '0;
    logic [7:0]  led2;

    data_mem_param #(.READ_LATENCY(1), .INIT_FILE("")) u_dut1 (
        .clk(clk), .rst_n(rst_n), .addr(addr1), .write_data(wd1), .memwrite(we1),
        .memread(re1), .sign_mask(sm1), .read_data(rd1), .led(led1),
        .clk_stall(stall1), .fault(fault1)
    );

    data_mem_param #(.READ_LATENCY(2), .INIT_FILE("")) u_dut2 (
        .clk(clk), .rst_n(rst_n), .addr(addr2), .write_data(wd2), .memwrite(we2),
        .memread(re2), .sign_mask(sm2), .read_data(rd2), .led(led2),
        .clk_stall(stall2), .fault(fault2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %h expected %h at cycle %0d", name, tag, act, exp, cyc);
        end
    endtask

    // Monitors: pop the entry due in this cycle, otherwise expect a quiet bus.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                chk("lat1 fault", e.tag, 32'(fault1), 32'(e.fault));
                if (e.is_load) chk("lat1 data", e.tag, rd1, e.data);
            end else begin
                chk("lat1 idle fault", 0, 32'(fault1), 32'h0);
            end
            chk("lat1 stall", 0, 32'(stall1), 32'h0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic stall_exp;
        if (rst_n) begin
            stall_exp = (q2.size() > 0) && q2[0].is_load && (q2[0].due == cyc + 1);
            chk("lat2 stall", 0, 32'(stall2), 32'(stall_exp));
            if (q2.size() > 0 && q2[0].due == cyc) begin
                e = q2.pop_front();
                chk("lat2 fault", e.tag, 32'(fault2), 32'(e.fault));
                if (e.is_load) chk("lat2 data", e.tag, rd2, e.data);
            end else begin
                chk("lat2 idle fault", 0, 32'(fault2), 32'h0);
            end
        end
    end

    task automatic drive(input int k, input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] sm);
        if (k == 1) begin
            addr1 = a; wd1 = wd; we1 = wr; re1 = rd; sm1 = sm;
        end else begin
            addr2 = a; wd2 = wd; we2 = wr; re2 = rd; sm2 = sm;
        end
    endtask

    task automatic acc(input int k, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] sm,
                       input logic [31:0] exp_data, input bit exp_fault);
        exp_t e;
        drive(k, wr, rd, a, wd, sm);
        @(posedge clk);
        #1;
        drive(k, 1'b0, 1'b0, a, wd, sm);
        tag_n++;
        e.is_load = rd;
        e.data    = exp_data;
        e.fault   = exp_fault;
        e.tag     = tag_n;
        if (k == 1) begin
            e.due = cyc;
            q1.push_back(e);
        end else begin
            e.due = rd ? cyc + 1 : cyc;
            q2.push_back(e);
            if (rd) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        #12 rst_n = 1'b1;

        // Latency 1
        acc(1, 1, 0, 32'h1004, 32'hDEADBEEF, 4'b0111, 32'h0, 0);
        acc(1, 0, 1, 32'h1004, 32'h0, 4'b0111, 32'hDEADBEEF, 0);
        acc(1, 1, 0, 32'h1007, 32'h00000080, 4'b0001, 32'h0, 0);
        acc(1, 0, 1, 32'h1007, 32'h0, 4'b1001, 32'hFFFFFF80, 0);
        acc(1, 0, 1, 32'h1007, 32'h0, 4'b0001, 32'h00000080, 0);
        acc(1, 0, 1, 32'h1004, 32'h0, 4'b0111, 32'h80ADBEEF, 0);
        acc(1, 0, 1, 32'h1005, 32'h0, 4'b1001, 32'hFFFFFFBE, 0);
        acc(1, 0, 1, 32'h1006, 32'h0, 4'b1011, 32'hFFFF80AD, 0);
        acc(1, 0, 1, 32'h1006, 32'h0, 4'b0011, 32'h000080AD, 0);
        acc(1, 1, 0, 32'h1000, 32'h0, 4'b0111, 32'h0, 0);
        acc(1, 1, 0, 32'h1002, 32'hFFFF1234, 4'b0011, 32'h0, 0);
        acc(1, 0, 1, 32'h1000, 32'h0, 4'b0111, 32'h12340000, 0);
        acc(1, 0, 1, 32'h1001, 32'h0, 4'b1011, 32'h0, 1);
        acc(1, 0, 1, 32'h1000, 32'h0, 4'b0111, 32'h12340000, 0);
        acc(1, 0, 1, 32'h1002, 32'h0, 4'b1011, 32'h00001234, 0);
        acc(1, 0, 1, 32'h1002, 32'h0, 4'b0111, 32'h0, 1);
        acc(1, 1, 0, 32'h1006, 32'h11111111, 4'b0111, 32'h0, 1);
        acc(1, 1, 1, 32'h1004, 32'h0, 4'b0111, 32'h80ADBEEF, 0);
        acc(1, 0, 1, 32'h1004, 32'h0, 4'b0111, 32'h80ADBEEF, 0);
        acc(1, 1, 0, 32'h2000, 32'h000000A5, 4'b0111, 32'h0, 0);
        chk("lat1 led", 0, 32'(led1), 32'hA5);
        acc(1, 0, 1, 32'h2000, 32'h0, 4'b0111, 32'h000000A5, 0);
        acc(1, 0, 1, 32'h2000, 32'h0, 4'b1001, 32'hFFFFFFA5, 0);
        acc(1, 1, 0, 32'h1FFC, 32'h11223344, 4'b0111, 32'h0, 0);
        acc(1, 1, 0, 32'h0FFC, 32'hCAFEF00D, 4'b0111, 32'h0, 1);
        acc(1, 1, 0, 32'h2004, 32'hCAFEF00D, 4'b0111, 32'h0, 1);
        acc(1, 0, 1, 32'h1FFC, 32'h0, 4'b0111, 32'h11223344, 0);
        acc(1, 0, 1, 32'h2004, 32'h0, 4'b0111, 32'h0, 1);
        chk("lat1 led kept", 0, 32'(led1), 32'hA5);

        // Latency 2
        acc(2, 1, 0, 32'h1004, 32'hDEADBEEF, 4'b0111, 32'h0, 0);
        acc(2, 0, 1, 32'h1004, 32'h0, 4'b0111, 32'hDEADBEEF, 0);
        // memread held through READ_WAIT with a faulting address and a store: all ignored
        drive(2, 1'b0, 1'b1, 32'h1004, 32'h0, 4'b0111);
        @(posedge clk);
        #1;
        tag_n++;
        e.is_load = 1'b1; e.data = 32'hDEADBEEF; e.fault = 1'b0; e.due = cyc + 1; e.tag = tag_n;
        q2.push_back(e);
        drive(2, 1'b1, 1'b1, 32'h1001, 32'h0, 4'b1011);
        @(posedge clk);
        #1;
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        acc(2, 0, 1, 32'h1004, 32'h0, 4'b0111, 32'hDEADBEEF, 0);
        acc(2, 0, 1, 32'h1001, 32'h0, 4'b1011, 32'h0, 1);
        acc(2, 1, 0, 32'h1007, 32'h00000080, 4'b0001, 32'h0, 0);
        acc(2, 0, 1, 32'h1007, 32'h0, 4'b1001, 32'hFFFFFF80, 0);
        acc(2, 1, 0, 32'h0FFC, 32'h0, 4'b0111, 32'h0, 1);
        acc(2, 1, 0, 32'h2000, 32'h000000A5, 4'b0111, 32'h0, 0);
        chk("lat2 led", 0, 32'(led2), 32'hA5);
        acc(2, 0, 1, 32'h2000, 32'h0, 4'b0111, 32'h000000A5, 0);

        // Reset in the middle of READ_WAIT
        drive(2, 1'b0, 1'b1, 32'h1004, 32'h0, 4'b0111);
        @(posedge clk);
        #1;
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        chk("rst stall", 0, 32'(stall2), 32'h0);
        chk("rst fault", 0, 32'(fault2), 32'h0);
        chk("rst led", 0, 32'(led2), 32'h0);
        chk("rst data", 0, rd2, 32'h0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("no stale data", 0, rd2, 32'h0);
        #1;
        acc(2, 0, 1, 32'h1004, 32'h0, 4'b0111, 32'h80ADBEEF, 0);
        acc(1, 0, 1, 32'h1FFC, 32'h0, 4'b0111, 32'h11223344, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", 0, 32'(q1.size() + q2.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_param.md
Name: data_mem_param

Overview:
- Parametrised next-generation data memory for the RV32I core. Sits between the MEM stage and a word-organised block RAM.
- Adds over the previous generation:
  - configurable depth, base address and LED/MMIO address;
  - asynchronous active-low reset;
  - optional two-cycle read with a `clk_stall` handshake;
  - LED register readback;
  - misalignment and range fault detection.
- Byte/halfword/word loads with sign/zero extension and byte-masked stores are retained.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2).
- BASE_ADDR, 32'h0000_1000, byte address of word 0; word-aligned.
- LED_ADDR, 32'h0000_2000, byte address of the LED register; must lie outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
- LED_WIDTH, 8, number of LED register bits driven to `led`.
- READ_LATENCY, 1, either 1 or 2; 2 inserts a registered output stage and a one-cycle stall.
- INIT_FILE, "verilog/data.hex", $readmemh image for the array; empty string means no initialisation.

Ports:
- clk  in  1  core clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  32  byte address.
- write_data  in  32  store data, right-aligned.
- memwrite  in  1  store request.
- memread  in  1  load request.
- sign_mask  in  4  [2:0] size: 001 byte, 011 half, 111 word; [3] 1 means sign-extend on load.
- read_data  out  32  aligned, extended load result.
- led  out  LED_WIDTH  LED register low bits.
- clk_stall  out  1  high means the core must hold its pipeline.
- fault  out  1  one-cycle pulse for a misaligned or out-of-range access.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE; read_data, clk_stall and fault go to 0; the LED register goes to 0.
  - Array contents are not reset.
  - Reset asserted during READ_WAIT abandons the read, and no stale data appears after release.
- Access decode:
  - `idx = (addr - BASE_ADDR) >> 2`.
  - In range when `addr - BASE_ADDR < 4*DEPTH_WORDS`, evaluated unsigned so addresses below the base wrap and fail.
  - Misaligned cases: half at `addr[0]=1`; word at `addr[1:0]≠0`.
  - Any other sign_mask[2:0] encoding is treated as a word access.
- Priority: memread beats memwrite in the same cycle; the write is dropped and fault stays 0.
- Stores (IDLE, memwrite=1, memread=0):
  - Byte: write_data[7:0] goes to lane `addr[1:0]`.
  - Half: write_data[15:0] goes to lanes {1,0} or {3,2} by `addr[1]`.
  - Word: all four lanes are written.
  - Unwritten lanes are preserved.
  - The write commits at the same edge it is sampled.
  - A store to LED_ADDR writes the full 32-bit LED register and does not touch the array.
  - A misaligned or out-of-range store (not LED_ADDR) writes nothing and pulses fault on the following cycle.
- Loads (IDLE, memread=1):
  - At the sampling edge, capture addr[1:0] and sign_mask, and read the array word (or the LED register when `addr=LED_ADDR`).
  - Lane extraction matches the store lanes; bit 3 of sign_mask selects sign or zero extension.
  - A faulting load returns 32'h0 and pulses fault at the same time read_data would become valid.
  - read_data holds its last value until the next load completes.
- FSM states:
  - IDLE
  - READ_WAIT (only reachable when READ_LATENCY=2)
- READ_LATENCY=1:
  - FSM stays in IDLE.
  - Load sampled at edge N; read_data valid after edge N+1's preceding edge, i.e. during cycle N+1.
  - clk_stall is always 0.
  - Back-to-back loads are accepted every cycle.
- READ_LATENCY=2:
  - Load sampled at edge N moves IDLE to READ_WAIT; clk_stall=1 during cycle N+1.
  - At edge N+1: output register loaded, READ_WAIT returns to IDLE, clk_stall=0.
  - read_data is valid in cycle N+2.
  - All inputs are ignored in READ_WAIT.
  - Stores never stall.
- fault is registered and high for exactly one cycle per faulting access.

Decomposition:
- Package data_mem_pkg holds:
  - sign_mask size encodings (SZ_BYTE=3'b001, SZ_HALF=3'b011, SZ_WORD=3'b111);
  - FSM state localparams (IDLE, READ_WAIT).
- One sub-module, data_mem_lane: combinational store-lane/byte-enable generation plus load extraction/extension, shared by both paths.
- The array stays in the top so that it infers block RAM.

Test Plan:
1. Word store then load: store 32'hDEADBEEF to 32'h1004; load word from 32'h1004 → read_data=32'hDEADBEEF in cycle N+1, fault=0.
2. Byte store and signed load:
   - Store 8'h80 to 32'h1007, then lb from 32'h1007 → 32'hFFFFFF80, and lbu → 32'h00000080.
   - Word at 32'h1004 becomes 32'h80ADBEEF.
3. Half handling:
   - sh of 16'h1234 at 32'h1002 over a word of 0 → word 32'h12340000.
   - lh at 32'h1001 → fault pulse, read_data=0, memory unchanged.
4. LED and range:
   - Store 32'h000000A5 to 32'h2000 → led=8'hA5; a load from 32'h2000 returns 32'h000000A5.
   - A store to BASE_ADDR-4 → fault=1, no write.
5. READ_LATENCY=2: load at N → clk_stall=1 only in N+1, data valid in N+2; a memread held high during N+1 causes no second access.
6. Reset: assert rst_n=0 mid-READ_WAIT with led=8'hA5 → clk_stall, fault and led go to 0 immediately; array contents are retained after release.
